// File: rtl/alu_op2_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op2_seq_if
// Description : Instruction-in / result-out handshake bundle for alu_op2_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op2_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] op2;
    logic            err;

    modport master (
        output in_valid, instr, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, result, op2, err
    );

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, result, op2, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_op2_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_op2_seq
// Description : Multi-cycle operand-2 sequencer: store address or shift.
//               Define ALU_OP2_BARREL_EN for a single-cycle barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op2_seq #(
    parameter int XLEN = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_op2_seq_if.slave bus
);

    localparam logic [6:0] c_OPC_STORE = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [2:0] c_F3_SL     = 3'b001;
    localparam logic [2:0] c_F3_SR     = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_STORE = 3'd0,
        K_SLL   = 3'd1,
        K_SRL   = 3'd2,
        K_SRA   = 3'd3,
        K_ERR   = 3'd4
    } kind_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_shamt;
    kind_t           w_kind;
    logic [XLEN-1:0] w_op2;
    logic [4:0]      w_cnt;
    logic            w_unused_fields;

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];
    // R-type takes the amount from rs2, I-type from the immediate field.
    assign w_shamt  = (w_opcode == c_OPC_OP) ? bus.rs2_val[4:0] : bus.instr[24:20];
    assign w_unused_fields = ^{bus.instr[19:15], bus.rs2_val[XLEN-1:5]};

    always_comb begin
        w_kind = K_ERR;
        w_op2  = '0;
        w_cnt  = '0;
        case (w_opcode)
            c_OPC_STORE: begin
                w_kind = K_STORE;
                w_op2  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            end
            c_OPC_OPIMM, c_OPC_OP: begin
                if (w_funct3 == c_F3_SL && w_funct7 == c_F7_ZERO) begin
                    w_kind = K_SLL;
                end else if (w_funct3 == c_F3_SR && w_funct7 == c_F7_ZERO) begin
                    w_kind = K_SRL;
                end else if (w_funct3 == c_F3_SR && w_funct7 == c_F7_ALT) begin
                    w_kind = K_SRA;
                end
                if (w_kind != K_ERR) begin
                    w_op2 = {{(XLEN-5){1'b0}}, w_shamt};
                    w_cnt = w_shamt;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t          r_state;
    kind_t           r_kind;
    logic [XLEN-1:0] r_work;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_op2;
    logic            r_err;
    logic            r_in_ready;
    logic            r_out_valid;

`ifdef ALU_OP2_BARREL_EN
    logic [XLEN-1:0] w_shifted;

    always_comb begin
        w_shifted = r_work;
        case (r_kind)
            K_SLL:   w_shifted = r_work << r_cnt;
            K_SRL:   w_shifted = r_work >> r_cnt;
            K_SRA:   w_shifted = $signed(r_work) >>> r_cnt;
            default: w_shifted = r_work;
        endcase
    end
`else
    logic [XLEN-1:0] w_step;

    always_comb begin
        w_step = r_work;
        case (r_kind)
            K_SLL:   w_step = {r_work[XLEN-2:0], 1'b0};
            K_SRL:   w_step = {1'b0, r_work[XLEN-1:1]};
            K_SRA:   w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_step = r_work;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_kind      <= K_ERR;
            r_work      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_op2       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_work     <= bus.rs1_val;
                        r_kind     <= w_kind;
                        r_op2      <= w_op2;
                        r_err      <= (w_kind == K_ERR);
                        r_cnt      <= w_cnt;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_kind)
                        K_STORE: begin
                            r_result    <= r_work + r_op2;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                        K_ERR: begin
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                        default: begin
`ifdef ALU_OP2_BARREL_EN
                            r_result    <= w_shifted;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
`else
                            // One bit per cycle; the zero-count cycle publishes.
                            if (r_cnt == 5'd0) begin
                                r_result    <= r_work;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_work <= w_step;
                                r_cnt  <= r_cnt - 5'd1;
                            end
`endif
                        end
                    endcase
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.op2       = r_op2;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op2_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op2_seq
// Description : Scoreboard bench for alu_op2_seq, directed and random cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op2_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op2_seq_if #(.XLEN(32)) bus ();

    alu_op2_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] op2;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    bit   stall_hold = 1'b0;
    bit   seen       = 1'b0;
    exp_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: decode from the instruction fields and compute with plain operators.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        int         n;
        bit         shift_ok;
        e.res = 32'd0; e.op2 = 32'd0; e.err = 1'b1; e.lat = 2; e.t0 = 0;
        shift_ok = (f3 == 3'd1 && f7 == 7'h00) || (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20));
        if (opc == 7'h23) begin
            e.op2 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            e.res = a + e.op2;
            e.err = 1'b0;
        end else if ((opc == 7'h13 || opc == 7'h33) && shift_ok) begin
            n     = (opc == 7'h33) ? int'(b[4:0]) : int'(ins[24:20]);
            e.op2 = n;
            e.err = 1'b0;
            if (f3 == 3'd1)      e.res = a << n;
            else if (f7 == 7'h0) e.res = a >> n;
            else                 e.res = $signed(a) >>> n;
`ifndef ALU_OP2_BARREL_EN
            e.lat = 2 + n;
`endif
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] res, input logic [31:0] op2, input logic err, input int lat);
        exp_t e;
        e.res = res; e.op2 = op2; e.err = err; e.lat = lat; e.t0 = 0;
        return e;
    endfunction

    // Consumer side: random back-pressure unless a stall is being forced.
    always @(posedge clk) begin
        #1;
        bus.out_ready = stall_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                cur = sbq[0];
                chk("result", bus.result, cur.res);
                chk("op2", bus.op2, cur.op2);
                chk("err", {31'd0, bus.err}, {31'd0, cur.err});
                chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc + 1 - cur.t0, cur.lat);
                end
                if (bus.out_ready) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input exp_t e, output int t0);
        int waitc = 0;
        @(negedge clk);
        bus.instr    = ins;
        bus.rs1_val  = a;
        bus.rs2_val  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 300 cycles");
            bus.in_valid = 1'b0;
            t0 = -1;
            return;
        end
        t0   = cyc + 1;
        e.t0 = t0;
        if (push) sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.instr    = $urandom;
        bus.rs1_val  = $urandom;
        bus.rs2_val  = $urandom;
    endtask

    task automatic wait_idle();
        int waitc = 0;
        while ((sbq.size() != 0 || !bus.in_ready) && waitc < 500) begin
            @(negedge clk);
            waitc++;
        end
        if (sbq.size() != 0 || !bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending, expected 0", sbq.size());
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins = $urandom;
        case ($urandom_range(0, 7))
            0: ins[6:0] = 7'h23;
            1: begin ins[6:0] = 7'h13; ins[14:12] = 3'd1; ins[31:25] = 7'h00; end
            2: begin ins[6:0] = 7'h13; ins[14:12] = 3'd5; ins[31:25] = 7'h00; end
            3: begin ins[6:0] = 7'h13; ins[14:12] = 3'd5; ins[31:25] = 7'h20; end
            4: begin ins[6:0] = 7'h33; ins[14:12] = 3'd1; ins[31:25] = 7'h00; end
            5: begin ins[6:0] = 7'h33; ins[14:12] = 3'd5; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            6: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h13 : 7'h33;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        int          t0;
        int          waitc;
        logic [31:0] ins, a, b;
        int          lat_srai;

        bus.in_valid = 1'b0;
        bus.instr    = '0;
        bus.rs1_val  = '0;
        bus.rs2_val  = '0;
`ifdef ALU_OP2_BARREL_EN
        lat_srai = 2;
`else
        lat_srai = 6;
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_op2", bus.op2, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);

        issue(32'hFE112E23, 32'h0000_1000, $urandom, 1'b1, mk(32'h0000_0FFC, 32'hFFFF_FFFC, 1'b0, 2), t0);
        wait_idle();
        issue(32'h4040D093, 32'h8000_00F0, $urandom, 1'b1, mk(32'hF800_000F, 32'd4, 1'b0, lat_srai), t0);
        wait_idle();
        issue(32'h002090B3, 32'h1234_5678, 32'hFFFF_FFE0, 1'b1, mk(32'h1234_5678, 32'd0, 1'b0, 2), t0);
        wait_idle();

        // LUI is unsupported; hold the consumer off for 5 cycles once it completes.
        stall_hold = 1'b1;
        issue(32'h123450B7, 32'hDEAD_BEEF, $urandom, 1'b1, mk(32'd0, 32'd0, 1'b1, 2), t0);
        waitc = 0;
        while (!bus.out_valid && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("lui_out_valid", {31'd0, bus.out_valid}, 32'd1);
        repeat (5) @(negedge clk);
        stall_hold = 1'b0;
        wait_idle();

        // Reset mid-flight on a long shift: must be dropped silently.
        issue(32'h01F0D093, 32'hFFFF_0000, $urandom, 1'b0, mk(32'd0, 32'd0, 1'b0, 0), t0);
        while (cyc < t0 + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("midrst_no_pulse", {31'd0, bus.out_valid}, 32'd0);
        issue(32'hFE112E23, 32'h0000_2000, $urandom, 1'b1, mk(32'h0000_1FFC, 32'hFFFF_FFFC, 1'b0, 2), t0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            ins = gen_instr();
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
            issue(ins, a, b, 1'b1, model(ins, a, b), t0);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
